// File: rtl/jtopl_pg_multi_if.sv
// Slot-sequenced port bundle for jtopl_pg_multi: per-slot operator inputs and the phase result.
// Handshake: out_valid is a one-cycle strobe that marks fresh phase_out/slot_out; there is no ready, the consumer must take it that cycle.
interface jtopl_pg_multi_if #(
    parameter int OUTW = 10
);
    logic            cen;
    logic [9:0]      fnum;
    logic [2:0]      block;
    logic [3:0]      mul;
    logic            vib_en;
    logic            dvb;
    logic            keyon_rise;
    logic [5:0]      slot_in;
    logic [OUTW-1:0] phase_out;
    logic [5:0]      slot_out;
    logic            out_valid;

    modport master (
        output cen, fnum, block, mul, vib_en, dvb, keyon_rise,
        input  slot_in, phase_out, slot_out, out_valid
    );

    modport slave (
        input  cen, fnum, block, mul, vib_en, dvb, keyon_rise,
        output slot_in, phase_out, slot_out, out_valid
    );
endinterface

// File: rtl/jtopl_pg_multi.sv
// Time-multiplexed 3-stage phase generator for all operator slots of an OPL-class core.
// Define JTOPL_PG_VIB_EN to build the vibrato counters and F-number offset logic.
module jtopl_pg_multi #(
    parameter int SLOTS  = 18,
    parameter int PHW    = 19,
    parameter int OUTW   = 10,
    parameter int VIBDIV = 1024
) (
    input  logic              clk,
    input  logic              rst,
    jtopl_pg_multi_if.slave   bus
);
    localparam int SIDX = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    logic [5:0]      slot_cnt;
    logic [11:0]     fnum_mod;

    logic [11:0]     s1_fmod;
    logic [2:0]      s1_block;
    logic [3:0]      s1_mul;
    logic            s1_kon;
    logic            s1_valid;
    logic [5:0]      s1_slot;

    logic [PHW-1:0]  s2_inc;
    logic            s2_kon;
    logic            s2_valid;
    logic [5:0]      s2_slot;

    logic [PHW-1:0]  phase_mem [SLOTS];
    logic [OUTW-1:0] phase_q;
    logic [5:0]      slot_q;
    logic            valid_q;

    logic            last_slot;
    assign last_slot = (slot_cnt == 6'(SLOTS - 1));

`ifdef JTOPL_PG_VIB_EN
    localparam int FCW = $clog2(VIBDIV);

    logic [FCW-1:0]  frame_cnt;
    logic [2:0]      vib_pos;
    logic [3:0]      full;
    logic [3:0]      half;
    logic [8:0]      offset;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
            vib_pos   <= 3'd0;
        end else if (bus.cen && last_slot) begin
            frame_cnt <= frame_cnt + 1'b1;
            if (&frame_cnt) vib_pos <= vib_pos + 3'd1;
        end
    end

    always_comb begin
        full   = bus.dvb ? {bus.fnum[9:7], 1'b0} : {1'b0, bus.fnum[9:7]};
        half   = {1'b0, full[3:1]};
        offset = 9'd0;
        if (bus.vib_en) begin
            case (vib_pos)
                3'd1, 3'd3: offset = {5'd0, half};
                3'd2:       offset = {5'd0, full};
                3'd5, 3'd7: offset = 9'd0 - {5'd0, half};
                3'd6:       offset = 9'd0 - {5'd0, full};
                default:    offset = 9'd0;
            endcase
        end
        fnum_mod = {bus.fnum, 2'b00} + {{3{offset[8]}}, offset};
    end
`else
    logic unused_vib;
    assign unused_vib = bus.vib_en ^ bus.dvb;
    assign fnum_mod   = {bus.fnum, 2'b00};
`endif

    // Block 2 leaves fnum_mod in place; the 19-bit staging keeps block 7 from losing MSBs.
    logic [16:0]     phinc;
    logic [4:0]      factor;
    logic [21:0]     prod;
    logic [PHW-1:0]  inc;

    always_comb begin
        phinc = 17'(({7'd0, s1_fmod} << s1_block) >> 2);
        case (s1_mul)
            4'd0:         factor = 5'd1;
            4'd1:         factor = 5'd2;
            4'd2:         factor = 5'd4;
            4'd3:         factor = 5'd6;
            4'd4:         factor = 5'd8;
            4'd5:         factor = 5'd10;
            4'd6:         factor = 5'd12;
            4'd7:         factor = 5'd14;
            4'd8:         factor = 5'd16;
            4'd9:         factor = 5'd18;
            4'd10, 4'd11: factor = 5'd20;
            4'd12, 4'd13: factor = 5'd24;
            default:      factor = 5'd30;
        endcase
        prod = {5'd0, phinc} * {17'd0, factor};
        inc  = PHW'(prod >> 1);
    end

    logic [SIDX-1:0] wr_idx;
    logic [PHW-1:0]  nxt_phase;

    always_comb begin
        wr_idx    = s2_slot[SIDX-1:0];
        nxt_phase = s2_kon ? '0 : phase_mem[wr_idx] + s2_inc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt <= 6'd0;
            s1_fmod  <= 12'd0;
            s1_block <= 3'd0;
            s1_mul   <= 4'd0;
            s1_kon   <= 1'b0;
            s1_valid <= 1'b0;
            s1_slot  <= 6'd0;
            s2_inc   <= '0;
            s2_kon   <= 1'b0;
            s2_valid <= 1'b0;
            s2_slot  <= 6'd0;
            for (int i = 0; i < SLOTS; i++) phase_mem[i] <= '0;
            phase_q  <= '0;
            slot_q   <= 6'd0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (bus.cen) begin
                slot_cnt <= last_slot ? 6'd0 : slot_cnt + 6'd1;
                s1_fmod  <= fnum_mod;
                s1_block <= bus.block;
                s1_mul   <= bus.mul;
                s1_kon   <= bus.keyon_rise;
                s1_slot  <= slot_cnt;
                s1_valid <= 1'b1;
                s2_inc   <= inc;
                s2_kon   <= s1_kon;
                s2_slot  <= s1_slot;
                s2_valid <= s1_valid;
                // The slot leaves stage 3 before it is sampled again, so this RMW never races itself.
                if (s2_valid) begin
                    phase_mem[wr_idx] <= nxt_phase;
                    phase_q           <= nxt_phase[PHW-1 -: OUTW];
                    slot_q            <= s2_slot;
                    valid_q           <= 1'b1;
                end
            end
        end
    end

    assign bus.slot_in   = slot_cnt;
    assign bus.phase_out = phase_q;
    assign bus.slot_out  = slot_q;
    assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_jtopl_pg_multi.sv
// Scoreboard bench for jtopl_pg_multi: arithmetic reference model feeds an expected queue, a negedge monitor checks.
module tb_jtopl_pg_multi;
    localparam int SLOTS  = 18;
    localparam int PHW    = 19;
    localparam int OUTW   = 10;
    localparam int VIBDIV = 1024;
    localparam int EW     = 32 + 6 + OUTW;

    logic clk = 1'b0;
    logic rst = 1'b1;

    jtopl_pg_multi_if #(.OUTW(OUTW)) bus ();

    jtopl_pg_multi #(
        .SLOTS(SLOTS), .PHW(PHW), .OUTW(OUTW), .VIBDIV(VIBDIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // reference model state and scoreboard
    logic [EW-1:0] exp_q[$];
    longint        m_phase[SLOTS];
    int            m_slot;
    int            m_frame;
    int            n_samp;
    int            checks;
    int            errors;

    function automatic longint model_inc(int f, int b, int m, bit ve, bit d, int vpos);
        int     factor2[16] = '{1, 2, 4, 6, 8, 10, 12, 14, 16, 18, 20, 20, 24, 24, 30, 30};
        int     full = (f / 128) * (d ? 2 : 1);
        int     half = full / 2;
        int     off  = 0;
        int     fm;
        longint ph;
`ifdef JTOPL_PG_VIB_EN
        if (ve) begin
            case (vpos)
                1, 3:    off = half;
                2:       off = full;
                5, 7:    off = -half;
                6:       off = -full;
                default: off = 0;
            endcase
        end
`endif
        fm = ((f * 4 + off) % 4096 + 4096) % 4096;
        ph = longint'(fm) * (longint'(1) << b) / 4;
        return (ph * factor2[m] / 2) % (longint'(1) << PHW);
    endfunction

    // driver tasks
    task automatic drive(input bit c, input int f, input int b, input int m,
                         input bit ve, input bit d, input bit k);
        longint inc;
        longint np;
        bus.cen        = c;
        bus.fnum       = 10'(f);
        bus.block      = 3'(b);
        bus.mul        = 4'(m);
        bus.vib_en     = ve;
        bus.dvb        = d;
        bus.keyon_rise = k;
        if (c) begin
            inc = model_inc(f, b, m, ve, d, (m_frame / VIBDIV) % 8);
            np  = k ? 0 : (m_phase[m_slot] + inc) % (longint'(1) << PHW);
            m_phase[m_slot] = np;
            n_samp++;
            exp_q.push_back({32'(n_samp + 2), 6'(m_slot), OUTW'(np >> (PHW - OUTW))});
            m_slot++;
            if (m_slot == SLOTS) begin
                m_slot = 0;
                m_frame++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_cycle();
        drive($urandom_range(0, 9) != 0, $urandom_range(0, 1023), $urandom_range(0, 7),
              $urandom_range(0, 15), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 30) == 0);
    endtask

    task automatic do_reset(input int n);
        rst     = 1'b1;
        bus.cen = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        exp_q.delete();
        for (int i = 0; i < SLOTS; i++) m_phase[i] = 0;
        m_slot  = 0;
        m_frame = 0;
        n_samp  = 0;
        rst     = 1'b0;
    endtask

    // monitor
    logic            last_cen = 1'b0;
    logic            last_rst = 1'b1;
    int              cen_count;
    int              mon_slot;
    logic [OUTW-1:0] prev_phase;
    logic [5:0]      prev_slot_out;
    logic [5:0]      prev_slot_in;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cen %0d)", name, act, exp, cen_count);
        end
    endtask

    always @(posedge clk) begin
        last_cen <= bus.cen;
        last_rst <= rst;
    end

    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (last_rst) begin
            chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
            chk("rst_phase_out", 64'(bus.phase_out), 64'd0);
            chk("rst_slot_out",  64'(bus.slot_out),  64'd0);
            chk("rst_slot_in",   64'(bus.slot_in),   64'd0);
            cen_count = 0;
            mon_slot  = 0;
        end else if (!last_cen) begin
            chk("hold_out_valid", 64'(bus.out_valid), 64'd0);
            chk("hold_phase_out", 64'(bus.phase_out), 64'(prev_phase));
            chk("hold_slot_out",  64'(bus.slot_out),  64'(prev_slot_out));
            chk("hold_slot_in",   64'(bus.slot_in),   64'(prev_slot_in));
        end else begin
            cen_count++;
            mon_slot = (mon_slot + 1) % SLOTS;
            chk("slot_in", 64'(bus.slot_in), 64'(mon_slot));
            if (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 32]) == cen_count) begin
                e = exp_q.pop_front();
                chk("out_valid", 64'(bus.out_valid), 64'd1);
                chk("slot_out",  64'(bus.slot_out),  64'(e[OUTW+5 -: 6]));
                chk("phase_out", 64'(bus.phase_out), 64'(e[OUTW-1:0]));
            end else begin
                chk("idle_out_valid", 64'(bus.out_valid), 64'd0);
            end
        end
        prev_phase    = bus.phase_out;
        prev_slot_out = bus.slot_out;
        prev_slot_in  = bus.slot_in;
    end

    // stimulus and final report
    initial begin
        bus.cen = 1'b0; bus.fnum = '0; bus.block = '0; bus.mul = '0;
        bus.vib_en = 1'b0; bus.dvb = 1'b0; bus.keyon_rise = 1'b0;
        checks = 0;
        errors = 0;
        do_reset(2);

        repeat (3 * SLOTS) drive(1'b1, 'h200, 2, 1, 1'b0, 1'b0, 1'b0);

        // large increment that wraps the accumulator, key-on on slot 5 in the 10th frame
        for (int fr = 0; fr < 12; fr++)
            for (int s = 0; s < SLOTS; s++)
                drive(1'b1, 'h200, 7, 15, 1'b0, 1'b0, fr == 9 && m_slot == 5);

        repeat (7) drive(1'b1, 'h200, 2, 1, 1'b0, 1'b0, 1'b0);
        repeat (5) drive(1'b0, 'h200, 2, 1, 1'b0, 1'b0, 1'b0);
        repeat (SLOTS) drive(1'b1, 'h200, 2, 1, 1'b0, 1'b0, 1'b0);

        repeat (60 * SLOTS) rand_cycle();

`ifdef JTOPL_PG_VIB_EN
        do_reset(1);
        for (int i = 0; i < (2 * VIBDIV + 2) * SLOTS; i++)
            drive(1'b1, 'h3FF, 2, 1, 1'(m_slot % 2), 1'b1, 1'b0);
`endif

        while (m_slot != 9) drive(1'b1, 'h200, 2, 1, 1'b0, 1'b0, 1'b0);
        do_reset(1);
        repeat (2 * SLOTS) drive(1'b1, 'h200, 2, 1, 1'b0, 1'b0, 1'b0);
        repeat (3) drive(1'b0, 'h200, 2, 1, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/jtopl_pg_multi.md
Name: jtopl_pg_multi

Overview:
- Time-multiplexed, pipelined phase generator for all operator slots of an OPL-class core.
- Per slot: applies the vibrato frequency offset, block shift and MUL factor to the F-number, then accumulates the result into per-slot phase storage.
- Inputs arrive one slot per cen from the register/slot sequencer; the phase output feeds the operator/sine lookup stage.

Parameters:
- SLOTS, 18, number of operator slots serviced per frame; 2..64.
- PHW, 19, width of each per-slot phase accumulator; 17..24.
- OUTW, 10, number of phase MSBs presented on phase_out; at most PHW.
- VIBDIV, 1024, frames per vibrato position step; power of two.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cen  in  1  clock enable; one slot is processed per cen=1 cycle
- fnum  in  10  F-number of the current slot
- block  in  3  octave of the current slot
- mul  in  4  MUL code of the current slot
- vib_en  in  1  vibrato enable for the current slot
- dvb  in  1  global vibrato depth; 0 = shallow, 1 = deep
- keyon_rise  in  1  key-on edge for the current slot; forces phase to 0
- slot_in  out  6  index of the slot whose inputs are sampled this cen
- phase_out  out  OUTW  phase MSBs of the slot leaving the pipeline
- slot_out  out  6  index of the slot on phase_out
- out_valid  out  1  one-cycle pulse coincident with the cen that updates phase_out

Behaviour:
- All state is clocked on clk. When rst=1, the next edge sets to zero: slot counter, vibrato counters, frame counter, all pipeline registers, all SLOTS phase entries, phase_out, slot_out and out_valid.
- cen=0: all state holds and out_valid=0.
- Slot counter: slot_in advances once per cen, 0..SLOTS-1. It wraps to 0 and increments the frame counter when leaving SLOTS-1.
- Vibrato position: 3-bit vib_pos increments when the frame counter wraps at VIBDIV. vib_pos wraps from 7 to 0.
- Stage 1 (cen k), frequency modulation:
  - full = fnum[9:7] shifted left by dvb; half = full >> 1.
  - Offset by vib_pos, 0..7: 0, +half, +full, +half, 0, -half, -full, -half.
  - Offset is forced to 0 when vib_en=0.
  - fnum_mod (12 bits) = {fnum, 2'b00} + sign-extended 9-bit offset, computed modulo 2^12.
  - Stage 1 latches fnum_mod, block, mul, keyon_rise and the slot index.
- Stage 2 (cen k+1), block shift:
  - phinc (17 bits) = fnum_mod placed so that block 2 gives fnum_mod unchanged.
  - Each block step above 2 shifts left by 1; block 0 and block 1 shift right by 2 and 1 respectively.
- Stage 2 (cen k+1), MUL:
  - mul codes 0..15 map to x2 factors 1,2,4,6,8,10,12,14,16,18,20,20,24,24,30,30.
  - inc = (phinc * factor) >> 1, truncated to PHW bits.
- Stage 3 (cen k+2), accumulate:
  - phase[s] = keyon_rise ? 0 : phase[s] + inc, modulo 2^PHW.
  - phase_out = new phase[s][PHW-1 -: OUTW]; slot_out = s; out_valid=1 for that cycle.
- Latency: exactly 2 cen pulses from input sampling to the phase_out update. The first valid output after reset appears on the 3rd cen.
- keyon_rise with nonzero inc: the reset wins, so the stored phase and phase_out are 0. Accumulation resumes from 0 on the slot's next frame.
- A slot's read-modify-write completes before that slot returns, so there is no hazard.
- rst asserted mid-frame:
  - In-flight pipeline contents are discarded.
  - Sequencing restarts at slot 0 with vib_pos 0.

Optional Feature:
- Macro: JTOPL_PG_VIB_EN.
- Defined: vibrato counters and the offset logic are built as described above.
- Undefined: offset is hard-wired to 0, vib_en and dvb are ignored, and the frame counter and vib_pos are not instantiated.
- Latency and all other behaviour are identical in both cases.

Test Plan:
- Reset, then cen every cycle, fnum=0x200, block=2, mul=1, vib_en=0 on all slots:
  - Each slot's phase increments by 0x800 per frame.
  - Slot 0's first output has phase_out = 0x800 >> (PHW-OUTW).
  - slot_out sequences 0..17 then wraps.
- Same fnum, block=7, mul=15 → inc = (0x800<<5)*30>>1 mod 2^19; check wrap-around of phase.
- Assert keyon_rise on slot 5 after 10 frames → slot 5 phase_out=0 that frame, then equals one inc on the following frame. Other slots are unaffected.
- With JTOPL_PG_VIB_EN defined, fnum=0x3FF, dvb=1, vib_en=1:
  - Advance VIBDIV*2 frames to reach vib_pos=2.
  - inc equals fnum_mod 0xFFC+14 mod 4096 = 0x00A at block 2, mul=1.
  - With vib_en=0, inc is 0xFFC.
- Drive cen low for 5 cycles mid-frame → outputs, slot_in and phases are frozen, and out_valid=0. The sequence resumes without a skipped slot.
- Assert rst at slot 9 → next edge: slot_in=0, phase_out=0, out_valid=0, all phases 0 on the following frame.
